// File: rtl/tt_serial_sub.sv
// Bit-serial subtractor, LSB first: diff = minuend - subtrahend over W enabled edges.
// start/ready/busy/done handshake; optional signed overflow via TT_SERIAL_SUB_SIGNED_EN.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   ena                  clock enable (low = hold everything)
//   start                request, accepted in IDLE
//   minuend, subtrahend  W-bit operands latched on accept
//   ready, busy, done    IDLE / RUN / DONE state flags
//   diff, borrow_out     result and final borrow, held until next result
//   overflow             signed overflow (0 unless TT_SERIAL_SUB_SIGNED_EN)
module tt_serial_sub #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  a_sh, b_sh;
  logic [W-2:0]  res_sh;
  logic [W-1:0]  res_nx;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic          a0, b0, d, borrow_nx, last;

  assign a0        = a_sh[0];
  assign b0        = b_sh[0];
  assign d         = a0 ^ b0 ^ borrow;
  assign borrow_nx = (~a0 & b0) | (~(a0 ^ b0) & borrow);
  assign res_nx    = {d, res_sh};
  assign last      = (cnt == CW'(W - 1));

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (ena) begin
      unique case (state)
        S_IDLE:  if (start) state_nx = S_RUN;
        S_RUN:   if (last) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (ena) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= minuend;
            b_sh   <= subtrahend;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx[W-1:1];
          borrow <= borrow_nx;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff       <= res_nx;
            borrow_out <= borrow_nx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_SERIAL_SUB_SIGNED_EN
  // On the last bit the shift regs hold the operand sign bits in [0]
  // and d is the result sign, so no separate sign capture is needed.
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ena && state == S_RUN && last) begin
      ovf_q <= (a0 != b0) && (d != a0);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
